pi1_arbiter: RTL and testbench
==============================

PI1_ARBITER -- requirements
Module: pi1_arbiter

Interface
REQ-001 Parameter MASTERCOUNT, default 2, number of pi1 masters (pu instances); legal range 2..16.
REQ-002 Parameter ARCHBITSZ, default 32, data width; ADDRBITSZ = ARCHBITSZ-clog2(ARCHBITSZ/8) word-address width.
REQ-003 clk_i  in  1  single clock; all state updates on posedge.
REQ-004 rst_i  in  1  asynchronous, active-low reset.
REQ-005 m_op_i  in  MASTERCOUNT*2  per-master pi1 op; master k in bits [2k+1:2k]; 00 NOOP, 01 WRITE, 10 READ, 11 READWRITE.
REQ-006 m_addr_i  in  MASTERCOUNT*ADDRBITSZ  per-master word address.
REQ-007 m_data_i  in  MASTERCOUNT*ARCHBITSZ  per-master write data.
REQ-008 m_sel_i  in  MASTERCOUNT*(ARCHBITSZ/8)  per-master byte select.
REQ-009 m_data_o  out  ARCHBITSZ  response data, shared by all masters.
REQ-010 m_rdy_o  out  MASTERCOUNT  per-master ready.
REQ-011 s_op_o, s_addr_o, s_data_o, s_sel_o  out  2/ADDRBITSZ/ARCHBITSZ/ARCHBITSZ/8  registered slave-side request.
REQ-012 s_data_i  in  ARCHBITSZ; s_rdy_i  in  1  slave response data and ready.

Function
REQ-013 Master request k accepted in a cycle with m_op_i[k]!=NOOP and m_rdy_o[k]=1; slave request accepted in a cycle with s_op_o!=NOOP and s_rdy_i=1.
REQ-014 FSM states IDLE, REQ, RESP; at most one transaction outstanding.
REQ-015 IDLE: winner = arbitration result among masters with op!=NOOP; m_rdy_o[k]=1 iff no master requests or k==winner; all other m_rdy_o bits 0.
REQ-016 IDLE with a winner: latch winner's op/addr/data/sel into s_*_o, record owner=winner, go REQ.
REQ-017 REQ: s_op_o held stable; m_rdy_o all 0; on s_rdy_i=1 set s_op_o=NOOP, go RESP.
REQ-018 RESP: m_rdy_o all 0; on s_rdy_i=1 register m_data_o<=s_data_i (all op types), go IDLE.
REQ-019 m_data_o holds its value outside the RESP->IDLE transition; valid for owner from the first cycle its m_rdy_o is 1 after acceptance.
REQ-020 Minimum latency: accept at T, s_op_o valid T+1, with s_rdy_i continuously 1 response visible in IDLE at T+3.
REQ-021 s_rdy_i low stalls REQ/RESP indefinitely; no timeout.
REQ-022 Requests from non-winners are ignored (not queued); masters hold op until accepted.
REQ-023 Owner may re-request in the same cycle its response becomes visible; arbitration treats it like any requester.
REQ-024 s_addr_o, s_data_o, s_sel_o change only on IDLE->REQ.

Reset
REQ-025 rst_i=0 forces asynchronously: state IDLE, s_op_o=NOOP, s_addr_o/s_data_o/s_sel_o/m_data_o=0, owner=MASTERCOUNT-1.
REQ-026 Reset during REQ/RESP drops the outstanding transaction; no response delivered; slave side sees NOOP.

Configuration
REQ-027 Macro PI1ARB_RR_EN defined: round-robin; winner = first requester at index owner+1, owner+2, ... modulo MASTERCOUNT.
REQ-028 PI1ARB_RR_EN undefined: fixed priority; winner = lowest-index requester; owner still recorded.

Verification
REQ-029 Single read: m0 READ addr 0x100, s_rdy_i=1, slave returns 0xDEADBEEF -> s_op_o=10 at T+1, m_data_o=0xDEADBEEF and m_rdy_o[0]=1 at T+3.
REQ-030 Contention, RR_EN: m0,m1 request continuously after reset -> grants m0,m1,m0,m1; without RR_EN -> m0,m0,m0,m0.
REQ-031 Slave stall: s_rdy_i=0 for 5 cycles in REQ -> s_op_o/s_addr_o stable, m_rdy_o=00, completion 5 cycles late.
REQ-032 Write: m1 WRITE addr 0x20 data 0x12345678 sel 0xF -> s_* match exactly; m_rdy_o[1] rises after RESP.
REQ-033 Async reset in RESP: rst_i low mid-cycle -> s_op_o=NOOP, state IDLE immediately; m_data_o=0; next request starts from owner=MASTERCOUNT-1.
REQ-034 Idle: all m_op_i NOOP -> m_rdy_o all 1, s_op_o NOOP, m_data_o unchanged.

Source files
------------

// File: rtl/pi1_arbiter.sv
// pi1_arbiter: shares one pi1 slave among MASTERCOUNT pi1 masters, one transaction in flight at a time.
// Latency: request accepted at T, slave request at T+1, response visible in IDLE at T+3 if the slave never stalls.
// Backpressure: s_rdy_i low holds REQ/RESP indefinitely; losing masters see m_rdy_o=0 and hold their op.
// Option macro PI1ARB_RR_EN: round-robin after the last owner; undefined selects fixed lowest-index priority.
module pi1_arbiter #(
  parameter int MASTERCOUNT = 2,
  parameter int ARCHBITSZ   = 32,
  localparam int SELBITSZ   = ARCHBITSZ / 8,
  localparam int ADDRBITSZ  = ARCHBITSZ - $clog2(SELBITSZ),
  localparam int IDXW       = $clog2(MASTERCOUNT)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [MASTERCOUNT*2-1:0]         m_op_i,
  input  logic [MASTERCOUNT*ADDRBITSZ-1:0] m_addr_i,
  input  logic [MASTERCOUNT*ARCHBITSZ-1:0] m_data_i,
  input  logic [MASTERCOUNT*SELBITSZ-1:0]  m_sel_i,
  output logic [ARCHBITSZ-1:0]             m_data_o,
  output logic [MASTERCOUNT-1:0]           m_rdy_o,
  output logic [1:0]                       s_op_o,
  output logic [ADDRBITSZ-1:0]             s_addr_o,
  output logic [ARCHBITSZ-1:0]             s_data_o,
  output logic [SELBITSZ-1:0]              s_sel_o,
  input  logic [ARCHBITSZ-1:0]             s_data_i,
  input  logic                             s_rdy_i
);

  localparam logic [1:0] OP_NOOP = 2'b00;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

  state_t                 state_q;
  logic [IDXW-1:0]        owner_q;
  logic [1:0]             s_op_q;
  logic [ADDRBITSZ-1:0]   s_addr_q;
  logic [ARCHBITSZ-1:0]   s_data_q;
  logic [SELBITSZ-1:0]    s_sel_q;
  logic [ARCHBITSZ-1:0]   m_data_q;

  logic [MASTERCOUNT-1:0] req;
  logic                   req_any;
  logic [IDXW-1:0]        win;

  // Flag every master presenting a non-NOOP op
  always_comb begin
    req = '0;
    for (int k = 0; k < MASTERCOUNT; k++) begin
      req[k] = (m_op_i[2*k +: 2] != OP_NOOP);
    end
  end

  assign req_any = |req;

  // Select the winner among the current requesters
  always_comb begin
    win = '0;
`ifdef PI1ARB_RR_EN
    // Scan farthest-first so the nearest requester after the last owner ends up winning.
    for (int i = MASTERCOUNT; i >= 1; i--) begin
      if (req[(int'(owner_q) + i) % MASTERCOUNT]) begin
        win = IDXW'((int'(owner_q) + i) % MASTERCOUNT);
      end
    end
`else
    for (int i = MASTERCOUNT - 1; i >= 0; i--) begin
      if (req[i]) begin
        win = IDXW'(i);
      end
    end
`endif
  end

`ifndef PI1ARB_RR_EN
  // The owner is still recorded under fixed priority but nothing reads it.
  logic unused_owner;
  assign unused_owner = ^owner_q;
`endif

  // Ready: only in IDLE, to everyone when nobody asks, else to the winner alone
  always_comb begin
    m_rdy_o = '0;
    if (state_q == ST_IDLE) begin
      if (!req_any) begin
        m_rdy_o = '1;
      end else begin
        m_rdy_o[win] = 1'b1;
      end
    end
  end

  // Transaction FSM: latch the winner's request, present it, then capture the response
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      owner_q  <= IDXW'(MASTERCOUNT - 1);
      s_op_q   <= OP_NOOP;
      s_addr_q <= '0;
      s_data_q <= '0;
      s_sel_q  <= '0;
      m_data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_any) begin
            s_op_q   <= m_op_i[int'(win)*2 +: 2];
            s_addr_q <= m_addr_i[int'(win)*ADDRBITSZ +: ADDRBITSZ];
            s_data_q <= m_data_i[int'(win)*ARCHBITSZ +: ARCHBITSZ];
            s_sel_q  <= m_sel_i[int'(win)*SELBITSZ +: SELBITSZ];
            owner_q  <= win;
            state_q  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (s_rdy_i) begin
            s_op_q  <= OP_NOOP;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (s_rdy_i) begin
            m_data_q <= s_data_i;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          s_op_q  <= OP_NOOP;
        end
      endcase
    end
  end

  assign s_op_o   = s_op_q;
  assign s_addr_o = s_addr_q;
  assign s_data_o = s_data_q;
  assign s_sel_o  = s_sel_q;
  assign m_data_o = m_data_q;

endmodule

// File: tb/tb_pi1_arbiter.sv
// tb_pi1_arbiter: directed and randomized transactions against a transaction-level reference model.
// Model tracks pending master requests, last owner and last response; arbitration follows the written rule.
// Arbitration expectation follows PI1ARB_RR_EN exactly as the design build does.
module tb_pi1_arbiter;

  localparam int MC = 2;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int AW = DW - $clog2(SW);

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [MC*2-1:0]   m_op_i;
  logic [MC*AW-1:0]  m_addr_i;
  logic [MC*DW-1:0]  m_data_i;
  logic [MC*SW-1:0]  m_sel_i;
  logic [DW-1:0]     m_data_o;
  logic [MC-1:0]     m_rdy_o;
  logic [1:0]        s_op_o;
  logic [AW-1:0]     s_addr_o;
  logic [DW-1:0]     s_data_o;
  logic [SW-1:0]     s_sel_o;
  logic [DW-1:0]     s_data_i;
  logic              s_rdy_i;

  pi1_arbiter #(.MASTERCOUNT(MC), .ARCHBITSZ(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_op_i(m_op_i), .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_sel_i(m_sel_i),
    .m_data_o(m_data_o), .m_rdy_o(m_rdy_o),
    .s_op_o(s_op_o), .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o),
    .s_data_i(s_data_i), .s_rdy_i(s_rdy_i)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [1:0]    op_m   [MC];
  logic [AW-1:0] addr_m [MC];
  logic [DW-1:0] data_m [MC];
  logic [SW-1:0] sel_m  [MC];
  int            owner_m;
  logic [DW-1:0] last_resp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < MC; k++) begin
      m_op_i[2*k +: 2]     = op_m[k];
      m_addr_i[k*AW +: AW] = addr_m[k];
      m_data_i[k*DW +: DW] = data_m[k];
      m_sel_i[k*SW +: SW]  = sel_m[k];
    end
  endtask

  function automatic int exp_winner();
`ifdef PI1ARB_RR_EN
    for (int i = 1; i <= MC; i++) begin
      if (op_m[(owner_m + i) % MC] != 2'b00) return (owner_m + i) % MC;
    end
`else
    for (int k = 0; k < MC; k++) begin
      if (op_m[k] != 2'b00) return k;
    end
`endif
    return -1;
  endfunction

  function automatic logic [MC-1:0] exp_rdy(input int w);
    logic [MC-1:0] e;
    e = '0;
    if (w < 0) e = '1;
    else e[w] = 1'b1;
    return e;
  endfunction

  task automatic set_req(input int k, input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    op_m[k] = op; addr_m[k] = a; data_m[k] = d; sel_m[k] = s;
  endtask

  // One IDLE arbitration step plus, if someone wins, the full request/response exchange.
  task automatic run_txn(input int stall_req, input int stall_resp, input logic [DW-1:0] resp);
    int w;
    logic [1:0] eop; logic [AW-1:0] ea; logic [DW-1:0] ed; logic [SW-1:0] es;
    drive_inputs();
    s_rdy_i  = 1'($urandom);
    s_data_i = $urandom;
    #1;
    w = exp_winner();
    chk("idle_rdy", 64'(m_rdy_o), 64'(exp_rdy(w)));
    if (w >= 0) begin
      eop = op_m[w]; ea = addr_m[w]; ed = data_m[w]; es = sel_m[w];
      tick();
      op_m[w] = 2'b00;
      owner_m = w;
      drive_inputs();
      for (int i = 0; i <= stall_req; i++) begin
        s_rdy_i  = (i == stall_req);
        s_data_i = $urandom;
        #1;
        chk("req_op",   64'(s_op_o),   64'(eop));
        chk("req_addr", 64'(s_addr_o), 64'(ea));
        chk("req_data", 64'(s_data_o), 64'(ed));
        chk("req_sel",  64'(s_sel_o),  64'(es));
        chk("req_rdy",  64'(m_rdy_o),  64'(0));
        tick();
      end
      for (int i = 0; i <= stall_resp; i++) begin
        s_rdy_i  = (i == stall_resp);
        s_data_i = (i == stall_resp) ? resp : DW'($urandom);
        #1;
        chk("resp_op",   64'(s_op_o),   64'(0));
        chk("resp_rdy",  64'(m_rdy_o),  64'(0));
        chk("resp_hold", 64'(m_data_o), 64'(last_resp));
        tick();
      end
      s_rdy_i = 1'b0;
      last_resp = resp;
      chk("resp_data", 64'(m_data_o), 64'(resp));
    end
  endtask

  logic [MC-1:0] grant_exp [4];

  initial begin
`ifdef PI1ARB_RR_EN
    grant_exp[0] = 2'b01; grant_exp[1] = 2'b10; grant_exp[2] = 2'b01; grant_exp[3] = 2'b10;
`else
    grant_exp[0] = 2'b01; grant_exp[1] = 2'b01; grant_exp[2] = 2'b01; grant_exp[3] = 2'b01;
`endif
    for (int k = 0; k < MC; k++) set_req(k, 2'b00, '0, '0, '0);
    owner_m = MC - 1;
    last_resp = '0;
    rst_i = 1'b0; s_rdy_i = 1'b0; s_data_i = '0;
    drive_inputs();

    // Reset state
    #12;
    chk("rst_sop",   64'(s_op_o),   64'(0));
    chk("rst_saddr", 64'(s_addr_o), 64'(0));
    chk("rst_sdata", 64'(s_data_o), 64'(0));
    chk("rst_ssel",  64'(s_sel_o),  64'(0));
    chk("rst_mdata", 64'(m_data_o), 64'(0));
    chk("rst_rdy",   64'(m_rdy_o),  64'(2'b11));
    tick();
    rst_i = 1'b1;

    // Contention: both masters request continuously from reset
    for (int n = 0; n < 4; n++) begin
      if (op_m[0] == 2'b00) set_req(0, 2'b10, AW'(16 + n), DW'(n), 4'hF);
      if (op_m[1] == 2'b00) set_req(1, 2'b10, AW'(32 + n), DW'(n), 4'hF);
      drive_inputs();
      #1;
      chk("grant_seq", 64'(m_rdy_o), 64'(grant_exp[n]));
      run_txn(0, 0, $urandom);
    end
    // Drain whatever is still pending
    while (exp_winner() >= 0) run_txn(0, 0, $urandom);

    // Single read, minimum latency
    set_req(0, 2'b10, AW'(32'h100), 32'h0, 4'hF);
    run_txn(0, 0, 32'hDEADBEEF);
    drive_inputs();
    #1;
    chk("read_rdy0", 64'(m_rdy_o[0]), 64'(1));

    // Slave stall of 5 cycles in REQ
    set_req(1, 2'b11, AW'(32'h3C), 32'hA5A5_0F0F, 4'h6);
    run_txn(5, 0, 32'h0BADF00D);

    // Write from master 1
    set_req(1, 2'b01, AW'(32'h20), 32'h12345678, 4'hF);
    run_txn(0, 2, 32'h0);
    drive_inputs();
    #1;
    chk("write_rdy1", 64'(m_rdy_o[1]), 64'(1));

    // Idle: nothing requested for several cycles
    for (int i = 0; i < 3; i++) begin
      s_rdy_i = 1'($urandom); s_data_i = $urandom;
      #1;
      chk("idle_all_rdy", 64'(m_rdy_o),  64'(2'b11));
      chk("idle_sop",     64'(s_op_o),   64'(0));
      chk("idle_mdata",   64'(m_data_o), 64'(last_resp));
      tick();
    end
    s_rdy_i = 1'b0;

    // Asynchronous reset while in RESP
    set_req(1, 2'b10, AW'(32'h44), 32'h0, 4'h3);
    drive_inputs();
    tick();
    op_m[1] = 2'b00; drive_inputs();
    s_rdy_i = 1'b1;
    tick();
    s_rdy_i = 1'b0;
    s_data_i = 32'hFFFF_FFFF;
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst_sop",   64'(s_op_o),   64'(0));
    chk("arst_mdata", 64'(m_data_o), 64'(0));
    chk("arst_saddr", 64'(s_addr_o), 64'(0));
    chk("arst_rdy",   64'(m_rdy_o),  64'(2'b11));
    tick();
    rst_i = 1'b1;
    owner_m = MC - 1;
    last_resp = '0;
    set_req(0, 2'b10, AW'(32'h8), 32'h0, 4'h1);
    set_req(1, 2'b01, AW'(32'h9), 32'h77, 4'h2);
    run_txn(1, 1, 32'hCAFE_0001);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < MC; k++) begin
        if (op_m[k] == 2'b00 && $urandom_range(0, 1) == 1) begin
          set_req(k, 2'($urandom_range(1, 3)), AW'($urandom), $urandom, SW'($urandom));
        end
      end
      run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
